// File: rtl/mux_pipe_nto1.sv
// N-to-1 selector (binary index or lowest-set-bit priority) feeding a registered
// pipeline boundary with stall/flush control, valid flag and chosen-index report.
module mux_pipe_nto1 #(
    parameter int                WIDTH       = 32,
    parameter int                N           = 4,
    parameter int                SEL_W       = 2,
    parameter int                MODE        = 0,
    parameter logic [WIDTH-1:0]  DEFAULT_VAL = {WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in,
    input  logic [SEL_W-1:0]     select,
    input  logic [N-1:0]         req,
    input  logic                 in_valid,
    input  logic                 stall,
    input  logic                 flush,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic [SEL_W-1:0]     out_idx,
    output logic                 out_nohit
);

    logic [WIDTH-1:0] bin_data_s;
    logic [SEL_W-1:0] bin_idx_s;
    logic [WIDTH-1:0] pri_data_s;
    logic [SEL_W-1:0] pri_idx_s;
    logic             pri_nohit_s;
    logic [WIDTH-1:0] data_s;
    logic [SEL_W-1:0] idx_s;
    logic             nohit_s;

    logic [WIDTH-1:0] out_r;
    logic             out_valid_r;
    logic [SEL_W-1:0] out_idx_r;
    logic             out_nohit_r;

    // Binary index: any select value not matching 0..N-2 falls through to input N-1,
    // which also covers out-of-range selects when N is not a power of two.
    always_comb begin
        bin_data_s = in[(N-1)*WIDTH +: WIDTH];
        bin_idx_s  = SEL_W'(N-1);
        for (int k = 0; k < N-1; k++) begin
            bin_data_s = (select == SEL_W'(k)) ? in[k*WIDTH +: WIDTH] : bin_data_s;
            bin_idx_s  = (select == SEL_W'(k)) ? SEL_W'(k)            : bin_idx_s;
        end
    end

    // Priority select: scan from the top so the lowest set request bit is applied last.
    always_comb begin
        pri_data_s  = DEFAULT_VAL;
        pri_idx_s   = {SEL_W{1'b0}};
        pri_nohit_s = 1'b1;
        for (int k = N-1; k >= 0; k--) begin
            pri_data_s  = req[k] ? in[k*WIDTH +: WIDTH] : pri_data_s;
            pri_idx_s   = req[k] ? SEL_W'(k)            : pri_idx_s;
            pri_nohit_s = req[k] ? 1'b0                 : pri_nohit_s;
        end
    end

    // Mode multiplexer between the two selection schemes.
    always_comb begin
        data_s  = bin_data_s;
        idx_s   = bin_idx_s;
        nohit_s = 1'b0;
        if (MODE == 1) begin
            data_s  = pri_data_s;
            idx_s   = pri_idx_s;
            nohit_s = pri_nohit_s;
        end else begin
            data_s  = bin_data_s;
            idx_s   = bin_idx_s;
            nohit_s = 1'b0;
        end
    end

    // Output stage: reset beats flush, flush beats stall, otherwise capture every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r       <= DEFAULT_VAL;
            out_valid_r <= 1'b0;
            out_idx_r   <= {SEL_W{1'b0}};
            out_nohit_r <= 1'b0;
        end else if (flush) begin
            out_r       <= DEFAULT_VAL;
            out_valid_r <= 1'b0;
            out_idx_r   <= {SEL_W{1'b0}};
            out_nohit_r <= 1'b0;
        end else if (!stall) begin
            out_r       <= data_s;
            out_valid_r <= in_valid;
            out_idx_r   <= idx_s;
            out_nohit_r <= nohit_s;
        end else begin
            out_r       <= out_r;
            out_valid_r <= out_valid_r;
            out_idx_r   <= out_idx_r;
            out_nohit_r <= out_nohit_r;
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign out_nohit = out_nohit_r;

endmodule

// File: tb/tb_mux_pipe_nto1.sv
// Bench for mux_pipe_nto1: three instances (N=4 binary, N=5 binary, N=4 priority)
// checked each cycle against a behavioural model, plus hand-computed spot checks.
module tb_mux_pipe_nto1;

    localparam logic [31:0] DEF2 = 32'hCAFEF00D;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [127:0]  in4 = 128'd0;
    logic [159:0]  in5 = 160'd0;
    logic [1:0]    select = 2'd0;
    logic [2:0]    sel5 = 3'd0;
    logic [3:0]    req = 4'd0;
    logic          in_valid = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;

    logic [31:0] o0, o1, o2;
    logic        v0, v1, v2;
    logic [1:0]  i0, i2;
    logic [2:0]  i1;
    logic        n0, n1, n2;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mux_pipe_nto1 #(.WIDTH(32), .N(4), .SEL_W(2), .MODE(0), .DEFAULT_VAL(32'h00000000)) u_bin4 (
        .clk(clk), .reset(reset), .in(in4), .select(select), .req(req),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out(o0), .out_valid(v0), .out_idx(i0), .out_nohit(n0));

    mux_pipe_nto1 #(.WIDTH(32), .N(5), .SEL_W(3), .MODE(0), .DEFAULT_VAL(32'h00000000)) u_bin5 (
        .clk(clk), .reset(reset), .in(in5), .select(sel5), .req(5'b00000),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out(o1), .out_valid(v1), .out_idx(i1), .out_nohit(n1));

    mux_pipe_nto1 #(.WIDTH(32), .N(4), .SEL_W(2), .MODE(1), .DEFAULT_VAL(DEF2)) u_pri4 (
        .clk(clk), .reset(reset), .in(in4), .select(select), .req(req),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out(o2), .out_valid(v2), .out_idx(i2), .out_nohit(n2));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: what each instance's pipeline register should hold
    logic [31:0] m_out [3];
    logic        m_val [3];
    int          m_idx [3];
    logic        m_nohit [3];
    bit          model_ok = 1'b0;

    function automatic void predict(input int inst, output logic [31:0] d,
                                    output int idx, output logic nohit);
        int n;
        int s;
        n = (inst == 1) ? 5 : 4;
        nohit = 1'b0;
        if (inst == 2) begin
            idx = 0;
            d = DEF2;
            nohit = 1'b1;
            for (int k = n-1; k >= 0; k--) begin
                if (req[k]) begin
                    idx = k;
                    d = in4[k*32 +: 32];
                    nohit = 1'b0;
                end
            end
        end else begin
            s = (inst == 1) ? int'(sel5) : int'(select);
            idx = (s >= n) ? n-1 : s;
            d = (inst == 1) ? in5[idx*32 +: 32] : in4[idx*32 +: 32];
        end
    endfunction

    always @(posedge clk) begin
        logic [31:0] d;
        int          idx;
        logic        nh;
        for (int i = 0; i < 3; i++) begin
            predict(i, d, idx, nh);
            if (reset || flush) begin
                m_out[i]   = (i == 2) ? DEF2 : 32'h0;
                m_val[i]   = 1'b0;
                m_idx[i]   = 0;
                m_nohit[i] = 1'b0;
            end else if (!stall) begin
                m_out[i]   = d;
                m_val[i]   = in_valid;
                m_idx[i]   = idx;
                m_nohit[i] = nh;
            end
        end
        if (reset) model_ok = 1'b1;
    end

    // Every-cycle comparison of all three instances against the model
    always @(negedge clk) begin
        if (model_ok) begin
            chk("u_bin4.out",   o0,      m_out[0]);
            chk("u_bin4.valid", 32'(v0), 32'(m_val[0]));
            chk("u_bin4.idx",   32'(i0), 32'(m_idx[0]));
            chk("u_bin4.nohit", 32'(n0), 32'(m_nohit[0]));
            chk("u_bin5.out",   o1,      m_out[1]);
            chk("u_bin5.valid", 32'(v1), 32'(m_val[1]));
            chk("u_bin5.idx",   32'(i1), 32'(m_idx[1]));
            chk("u_bin5.nohit", 32'(n1), 32'(m_nohit[1]));
            chk("u_pri4.out",   o2,      m_out[2]);
            chk("u_pri4.valid", 32'(v2), 32'(m_val[2]));
            chk("u_pri4.idx",   32'(i2), 32'(m_idx[2]));
            chk("u_pri4.nohit", 32'(n2), 32'(m_nohit[2]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with all inputs high and valid asserted
        in4 = {4{32'hFFFFFFFF}};
        in5 = {5{32'hFFFFFFFF}};
        req = 4'b1111;
        in_valid = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        chk("lit.reset.out0",  o0, 32'h00000000);
        chk("lit.reset.val0",  32'(v0), 32'd0);
        chk("lit.reset.idx0",  32'(i0), 32'd0);
        chk("lit.reset.nh2",   32'(n2), 32'd0);
        chk("lit.reset.out2",  o2, DEF2);

        // Binary sweep on N=4, N=5 sweeps too and ends on an out-of-range select
        in4 = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        in5 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            sel5 = 3'(s + 4);
            tick();
            chk("lit.sweep.out0", o0, {4{8'(s * 17)}});
            chk("lit.sweep.idx0", 32'(i0), 32'(s));
            chk("lit.sweep.val0", 32'(v0), 32'd1);
        end
        chk("lit.oor.out1", o1, 32'h44444444);
        chk("lit.oor.idx1", 32'(i1), 32'd4);
        sel5 = 3'd2;
        tick();
        chk("lit.sel2.out1", o1, 32'h22222222);

        // Priority mode
        req = 4'b1010;
        tick();
        chk("lit.pri1010.out", o2, 32'h11111111);
        chk("lit.pri1010.idx", 32'(i2), 32'd1);
        req = 4'b1000;
        tick();
        chk("lit.pri1000.out", o2, 32'h33333333);
        req = 4'b0000;
        tick();
        chk("lit.pri0.out",   o2, DEF2);
        chk("lit.pri0.nohit", 32'(n2), 32'd1);
        chk("lit.pri0.valid", 32'(v2), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("lit.pri0.inval", 32'(v2), 32'd0);

        // Stall holds a captured value while inputs churn
        in_valid = 1'b1;
        in4[31:0] = 32'hDEADBEEF;
        select = 2'd0;
        req = 4'b0001;
        tick();
        chk("lit.cap.out0", o0, 32'hDEADBEEF);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            select = 2'(c + 1);
            req = 4'(4'b0010 << c);
            in4[31:0] = 32'h12340000 + 32'(c);
            tick();
            chk("lit.stall.out0", o0, 32'hDEADBEEF);
            chk("lit.stall.idx0", 32'(i0), 32'd0);
        end
        stall = 1'b0;
        select = 2'd2;
        tick();
        chk("lit.unstall.out0", o0, 32'h22222222);

        // Flush overrides stall
        stall = 1'b1;
        flush = 1'b1;
        tick();
        chk("lit.flush.out0", o0, 32'h00000000);
        chk("lit.flush.val0", 32'(v0), 32'd0);
        chk("lit.flush.out2", o2, DEF2);
        flush = 1'b0;
        stall = 1'b0;
        select = 2'd1;
        tick();
        chk("lit.recap.out0", o0, 32'h11111111);

        // Reset overrides a pending stall and discards the held value
        reset = 1'b1;
        stall = 1'b1;
        tick();
        chk("lit.rststall.out0", o0, 32'h00000000);
        chk("lit.rststall.val0", 32'(v0), 32'd0);
        reset = 1'b0;
        stall = 1'b0;

        // Invalid capture still latches data
        in_valid = 1'b0;
        select = 2'd3;
        tick();
        chk("lit.inval.out0", o0, 32'h33333333);
        chk("lit.inval.val0", 32'(v0), 32'd0);

        // A few mixed back-to-back cycles for the model to cover
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            select = 2'(c);
            sel5 = 3'(7 - c);
            req = 4'(c * 3);
            flush = (c == 5);
            stall = (c == 2 || c == 3);
            tick();
        end
        flush = 1'b0;
        stall = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mux_pipe_nto1.md
Name: mux_pipe_nto1

Overview:
- Parametrised N-to-1 selector with a registered output stage.
- Used in the RV32IM pipeline for forwarding, writeback and PC-source selection where the chosen value must be latched into a pipeline boundary.
- Supports binary-index or one-hot/priority select, with stall (hold) and flush (bubble) control.
- Reports a valid flag and the index that was actually chosen, for hazard and debug logic.

Parameters:
- WIDTH, 32, data width of each input and the output.
- N, 4, number of inputs; legal range 2..16.
- SEL_W, 2, width of the binary select; must equal ceil(log2(N)).
- MODE, 0, select mode: 0 = binary index, 1 = priority one-hot (lowest set bit wins).
- DEFAULT_VAL, 32'h00000000, output value used for flush, reset, and MODE 1 with no request bit set.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN  input  N*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- SELECT  input  SEL_W  binary select; used only when MODE=0.
- REQ  input  N  one-hot/priority request vector; used only when MODE=1.
- IN_VALID  input  1  the current inputs and select are meaningful.
- STALL  input  1  hold all registered outputs.
- FLUSH  input  1  replace the next registered value with a bubble.
- OUT  output  WIDTH  registered selected data.
- OUT_VALID  output  1  OUT holds a valid selection.
- OUT_IDX  output  SEL_W  index of the input captured in OUT.
- OUT_NOHIT  output  1  MODE 1 only: REQ was all zero when captured.

Behaviour:
- Reset:
  - When RESET=1 at a rising edge: OUT=DEFAULT_VAL, OUT_VALID=0, OUT_IDX=0, OUT_NOHIT=0.
  - RESET has priority over FLUSH, STALL and capture.
  - Reset asserted mid-operation discards any held value.
- Combinational select, MODE 0:
  - idx = SELECT.
  - If SELECT >= N, the last input (N-1) is chosen and idx = N-1.
  - nohit = 0.
- Combinational select, MODE 1:
  - idx = the lowest k with REQ[k]=1, and data = IN[k].
  - If REQ is all zero: data = DEFAULT_VAL, idx = 0, nohit = 1.
- Register update, in priority order, evaluated each rising edge:
  1. RESET: as above.
  2. FLUSH=1: OUT=DEFAULT_VAL, OUT_VALID=0, OUT_IDX=0, OUT_NOHIT=0. FLUSH overrides STALL.
  3. STALL=1: all outputs hold their previous values; inputs are ignored.
  4. Otherwise: OUT=data, OUT_IDX=idx, OUT_NOHIT=nohit, OUT_VALID=IN_VALID.
     - When IN_VALID=0, data is still captured, but OUT_VALID=0.
- Latency:
  - Exactly 1 cycle from inputs to OUT when not stalled.
  - No combinational path from any input to any output.
- Stalls:
  - Back-to-back captures every cycle are supported.
  - A stall of any length holds OUT bit-exact.
- X handling: OUT must never be X after reset, whatever the SELECT or REQ value.
- Widths: no arithmetic; OUT_IDX is zero-extended from the computed index to SEL_W.

Test Plan:
- Reset: RESET=1 for 2 cycles with IN all 0xFFFFFFFF, IN_VALID=1 -> OUT=0, OUT_VALID=0, OUT_IDX=0, OUT_NOHIT=0; after release, OUT reflects the selection 1 cycle later.
- MODE 0 sweep: IN={0x33333333,0x22222222,0x11111111,0x00000000} (IN3..IN0), SELECT=0,1,2,3 on consecutive cycles with IN_VALID=1 -> one cycle later, OUT = 0x00000000, 0x11111111, 0x22222222, 0x33333333 with OUT_IDX = 0, 1, 2, 3 and OUT_VALID=1 throughout.
- MODE 0 out of range: N=5, SEL_W=3, SELECT=7 -> OUT=IN4, OUT_IDX=4.
- MODE 1 priority, N=4:
  - REQ=4'b1010 -> OUT=IN1, OUT_IDX=1.
  - REQ=4'b1000 -> OUT=IN3.
  - REQ=0 -> OUT=DEFAULT_VAL, OUT_NOHIT=1, OUT_VALID equal to IN_VALID.
- Stall: capture 0xDEADBEEF, then STALL=1 for 3 cycles while IN and SELECT change -> OUT stays 0xDEADBEEF and OUT_IDX is unchanged; on the cycle STALL drops, the new value is captured.
- Flush and reset priority:
  - STALL=1 and FLUSH=1 together with OUT_VALID=1 -> next cycle OUT=DEFAULT_VAL, OUT_VALID=0.
  - RESET=1 together with FLUSH=0 and STALL=1 -> reset values.
  - IN_VALID=0 capture -> OUT_VALID=0, OUT=selected data.
